midi_tx: RTL and testbench
==========================

MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 8, sample clocks per serial bit; legal values 2..255.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, transmit queue entries; legal values are powers of 2, 2..16.
REQ-003 SHALL provide port clk  input  1  sample clock (125 kHz); all logic on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL provide port midi_data  input  8  byte to queue.
REQ-006 SHALL provide port midi_data_wr  input  1  write strobe; one byte per high cycle.
REQ-007 SHALL provide port midi_data_full  output  1  queue full, registered.
REQ-008 SHALL provide port midi_ovf  output  1  one-cycle pulse when a write is dropped.
REQ-009 SHALL provide port midi_busy  output  1  high while the queue is non-empty or a frame is in progress.
REQ-010 SHALL provide port midi_out  output  1  serial MIDI line, idle high, registered.

Function
REQ-011 SHALL push midi_data on a rising edge with midi_data_wr=1 and midi_data_full=0.
REQ-012 SHALL drop a write seen while midi_data_full=1, even if a pop occurs on the same edge, and SHALL pulse midi_ovf for exactly one cycle.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE with queue non-empty SHALL pop one byte on the next edge, load the shift register, and enter START; midi_out SHALL fall 2 edges after the accepting write edge.
REQ-015 START SHALL drive 0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive 8 bits, LSB first, CLKS_PER_BIT cycles each; a 3-bit counter SHALL select the bit.
REQ-017 STOP SHALL drive 1 for CLKS_PER_BIT cycles, then enter START directly if the queue is non-empty (no idle gap), else IDLE.
REQ-018 A frame SHALL be exactly 10*CLKS_PER_BIT cycles; the bit-time counter SHALL wrap to 0 at CLKS_PER_BIT-1.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-020 midi_busy SHALL deassert on the edge that returns the FSM to IDLE with the queue empty.

Reset
REQ-021 rst SHALL asynchronously force state IDLE, queue empty, midi_out=1, midi_busy=0, midi_data_full=0, midi_ovf=0, and running status cleared.
REQ-022 rst mid-frame SHALL abort the frame with no partial frame resumed, and SHALL discard all queued bytes.

Configuration
REQ-023 Macro MIDI_TX_RUNNING_STATUS_EN defined: SHALL record the last transmitted channel status byte (0x80-0xEF).
REQ-024 With the macro, a popped status byte equal to the recorded byte SHALL be discarded without a frame, and the next byte SHALL be evaluated on the following cycle.
REQ-025 With the macro, bytes 0xF0-0xF7 SHALL clear the recorded status, and bytes 0xF8-0xFF SHALL be sent without affecting it.
REQ-026 With the macro undefined, every queued byte SHALL be transmitted verbatim and no status register SHALL exist.

Structure
REQ-027 Package midi_pkg SHALL hold the FSM state enum, the status-byte range constants, and the idle line level.
REQ-028 Queue storage SHALL be a sub-module midi_fifo (synchronous write/pop, full and empty flags); the FSM and shifter SHALL live in midi_tx.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-029 Write 0x80 -> midi_out low 8 clks; bits 0,0,0,0,0,0,0,1 at 8 clks each; high 8 clks; 80 clks total; midi_busy then low.
REQ-030 Write 0x90, 0x3C, 0x40 on consecutive cycles -> three contiguous frames, 240 clks, no extra high cycles between frames.
REQ-031 Hold FSM in a frame, write 4 bytes then a 5th -> midi_data_full=1, one midi_ovf pulse, 5th byte never transmitted.
REQ-032 Queue 0x90,0x3C,0x40,0x90,0x3E,0x40 -> 5 frames with the macro (2nd 0x90 omitted), 6 frames without it.
REQ-033 With the macro, queue 0x90,0x3C,0xF8,0x90 -> 0x90, 0x3C, 0xF8 sent and 2nd 0x90 omitted; replacing 0xF8 with 0xF0 -> 2nd 0x90 sent.
REQ-034 Assert rst during data bit 3 -> midi_out=1 immediately, midi_busy=0; then write 0x01 -> a correct 80-clk frame, and looped into midi_rx it yields midi_data=0x01.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared FSM state type, MIDI status-byte ranges and line level for the MIDI transmitter.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] CHAN_STATUS_MIN = 8'h80;
    localparam logic [7:0] CHAN_STATUS_MAX = 8'hEF;
    localparam logic [7:0] SYS_COMMON_MIN  = 8'hF0;
    localparam logic [7:0] SYS_COMMON_MAX  = 8'hF7;

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic is_chan_status(input logic [7:0] b);
        return (b >= CHAN_STATUS_MIN) && (b <= CHAN_STATUS_MAX);
    endfunction

    function automatic logic is_sys_common(input logic [7:0] b);
        return (b >= SYS_COMMON_MIN) && (b <= SYS_COMMON_MAX);
    endfunction

endpackage

// File: rtl/midi_fifo.sv
// Show-ahead byte queue for the MIDI transmitter: synchronous write/pop,
// registered full/empty flags and a one-cycle pulse for each dropped write.
module midi_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push;
    logic             take;

    // A write arriving while full is dropped even if a pop frees a slot on the same edge.
    assign push = wr && !full;
    assign take = pop && !empty;

    always_comb begin
        count_next = count;
        if (push && !take) begin
            count_next = count + (AW + 1)'(1);
        end else if (take && !push) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (take) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
            ovf   <= wr && full;
        end
    end

    // NOTE: storage has no reset; the empty flag guards every stale entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/midi_tx.sv
// MIDI serial transmitter: byte queue, 8N1 framing FSM and shifter.
// Define MIDI_TX_RUNNING_STATUS_EN to suppress repeated channel status bytes.
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] midi_data,
    input  logic       midi_data_wr,
    output logic       midi_data_full,
    output logic       midi_ovf,
    output logic       midi_busy,
    output logic       midi_out
);

    localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] tick;
    logic       tick_last;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       pop;
    logic       load;
    logic       skip;
    logic       line;

    midi_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_data(midi_data),
        .wr     (midi_data_wr),
        .pop    (pop),
        .rd_data(fifo_data),
        .full   (midi_data_full),
        .empty  (fifo_empty),
        .ovf    (midi_ovf)
    );

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic       rs_valid;
    logic [7:0] rs_byte;

    assign skip = is_chan_status(fifo_data) && rs_valid && (fifo_data == rs_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_valid <= 1'b0;
            rs_byte  <= '0;
        end else if (load) begin
            if (is_chan_status(fifo_data)) begin
                rs_valid <= 1'b1;
                rs_byte  <= fifo_data;
            end else if (is_sys_common(fifo_data)) begin
                rs_valid <= 1'b0;
            end
        end
    end
`else
    assign skip = 1'b0;
`endif

    assign tick_last = (tick == TICK_LAST);
    assign midi_busy = (state != IDLE) || !fifo_empty;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!skip) begin
                        load       = 1'b1;
                        state_next = START;
                    end
                end
            end
            START: begin
                if (tick_last) state_next = DATA;
            end
            DATA: begin
                if (tick_last && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (tick_last) begin
                    state_next = IDLE;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (!skip) begin
                            load       = 1'b1;
                            state_next = START;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        line = LINE_IDLE;
        unique case (state)
            START:   line = ~LINE_IDLE;
            DATA:    line = shreg[0];
            default: line = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            midi_out <= LINE_IDLE;
        end else begin
            if (load) begin
                tick    <= '0;
                bit_idx <= '0;
                shreg   <= fifo_data;
            end else if (state != IDLE) begin
                tick <= tick_last ? '0 : tick + 8'd1;
                if ((state == DATA) && tick_last) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end
            midi_out <= line;
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: frame-timeline reference model, per-cycle compare,
// line decoder and directed plus randomized stimulus. Honours MIDI_TX_RUNNING_STATUS_EN.
`timescale 1ns/1ns
module tb_midi_tx;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] midi_data;
    logic       midi_data_wr;
    logic       midi_data_full;
    logic       midi_ovf;
    logic       midi_busy;
    logic       midi_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ovf_cnt = 0;

    midi_tx #(
        .CLKS_PER_BIT(N),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .midi_data     (midi_data),
        .midi_data_wr  (midi_data_wr),
        .midi_data_full(midi_data_full),
        .midi_ovf      (midi_ovf),
        .midi_busy     (midi_busy),
        .midi_out      (midi_out)
    );

    always #4000 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue and "cycles left in the current frame".
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    int         rem = 0;
    logic [7:0] cur = '0;
    bit         rs_v = 0;
    logic [7:0] rs_b = '0;
    bit         full_pre;
    bit         drop;
    logic [7:0] b;
    logic       e_out = 1'b1;
    logic       e_full = 1'b0;
    logic       e_ovf = 1'b0;
    logic       e_busy = 1'b0;

    function automatic logic frame_level(input int r, input logic [7:0] d);
        int idx;
        if (r == 0) return 1'b1;
        idx = (10 * N - r) / N;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return d[idx-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            sent_q.delete();
            rem = 0;
            rs_v = 0;
            e_out = 1'b1;
            e_full = 1'b0;
            e_ovf = 1'b0;
            e_busy = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            e_out = frame_level(rem, cur);
            e_ovf = midi_data_wr && full_pre;
            if (rem > 0) rem--;
            if (rem == 0 && mq.size() > 0) begin
                b = mq.pop_front();
                drop = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
                if (b >= 8'h80 && b <= 8'hEF) begin
                    if (rs_v && b == rs_b) drop = 1;
                    else begin
                        rs_v = 1;
                        rs_b = b;
                    end
                end else if (b >= 8'hF0 && b <= 8'hF7) begin
                    rs_v = 0;
                end
`endif
                if (!drop) begin
                    cur = b;
                    rem = 10 * N;
                    sent_q.push_back(b);
                end
            end
            if (midi_data_wr && !full_pre) mq.push_back(midi_data);
            e_full = (mq.size() == DEPTH);
            e_busy = (rem > 0) || (mq.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out", midi_out, 1);
            check("rst_busy", midi_busy, 0);
            check("rst_full", midi_data_full, 0);
            check("rst_ovf", midi_ovf, 0);
        end else begin
            check("midi_out", midi_out, e_out);
            check("midi_busy", midi_busy, e_busy);
            check("midi_full", midi_data_full, e_full);
            check("midi_ovf", midi_ovf, e_ovf);
        end
        if (midi_ovf === 1'b1) ovf_cnt++;
    end

    // Line decoder: samples mid-bit, records each start-bit fall and received byte.
    logic [7:0] rx_q[$];
    int         fall_q[$];
    int         rx_pos = -1;
    logic [7:0] rx_sh = '0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_pos = -1;
            rx_q.delete();
            fall_q.delete();
        end else if (rx_pos < 0) begin
            if (midi_out === 1'b0) begin
                rx_pos = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            rx_pos++;
            if (rx_pos == N / 2) begin
                check("rx_start_bit", midi_out, 0);
            end else if (rx_pos > N / 2 && (rx_pos - N / 2) % N == 0) begin
                if ((rx_pos - N / 2) / N <= 8) begin
                    rx_sh = {midi_out, rx_sh[7:1]};
                end else begin
                    check("rx_stop_bit", midi_out, 1);
                    rx_q.push_back(rx_sh);
                    rx_pos = -1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        midi_data_wr = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        ovf_cnt = 0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        midi_data = d;
        midi_data_wr = 1'b1;
        tick(1);
        midi_data_wr = 1'b0;
    endtask

    task automatic write_paced(input logic [7:0] d);
        int n = 0;
        while (midi_data_full && n < 2000) begin
            tick(1);
            n++;
        end
        if (midi_data_full) check("full_timeout", midi_data_full, 0);
        write_byte(d);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (midi_busy && n < budget) begin
            tick(1);
            n++;
        end
        if (midi_busy) check("busy_timeout", midi_busy, 0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp[$]);
        check($sformatf("%s_count", tag), rx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
        end
    endtask

    initial begin
        #800_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e[$];
        logic [7:0] d;
        int         w;
        int         prob;

        rst = 1'b1;
        midi_data = '0;
        midi_data_wr = 1'b0;
        tick(3);
        check("reset_out", midi_out, 1);
        check("reset_busy", midi_busy, 0);
        check("reset_full", midi_data_full, 0);
        rst = 1'b0;
        tick(2);

        // Single 0x80 frame: fall two edges after the write, busy drops 81 edges later.
        do_reset();
        write_byte(8'h80);
        w = cyc;
        wait_idle(200);
        check("s1_busy_len", cyc - w, 81);
        tick(3);
        check("s1_fall_latency", (fall_q.size() > 0) ? fall_q[0] - w : -1, 2);
        e = {8'h80};
        check_rx("s1_rx", e);

        // Three back-to-back frames, 80 cycles apart, 240 cycles total.
        do_reset();
        midi_data = 8'h90;
        midi_data_wr = 1'b1;
        tick(1);
        w = cyc;
        midi_data = 8'h3C;
        tick(1);
        midi_data = 8'h40;
        tick(1);
        midi_data_wr = 1'b0;
        wait_idle(400);
        check("s2_busy_len", cyc - w, 241);
        tick(3);
        check("s2_fall0", (fall_q.size() > 0) ? fall_q[0] - w : -1, 2);
        check("s2_gap1", (fall_q.size() > 2) ? fall_q[1] - fall_q[0] : -1, 80);
        check("s2_gap2", (fall_q.size() > 2) ? fall_q[2] - fall_q[1] : -1, 80);
        e = {8'h90, 8'h3C, 8'h40};
        check_rx("s2_rx", e);

        // Overflow: one byte in flight, four queued, fifth dropped.
        do_reset();
        write_byte(8'h55);
        tick(1);
        midi_data_wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            midi_data = 8'(i);
            tick(1);
        end
        check("s3_full", midi_data_full, 1);
        midi_data = 8'hAA;
        tick(1);
        check("s3_ovf_pulse", midi_ovf, 1);
        midi_data_wr = 1'b0;
        tick(1);
        check("s3_ovf_end", midi_ovf, 0);
        wait_idle(600);
        tick(3);
        check("s3_ovf_count", ovf_cnt, 1);
        e = {8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
        check_rx("s3_rx", e);

        // Repeated note-on status.
        do_reset();
        e = {8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40};
        foreach (e[i]) write_paced(e[i]);
        wait_idle(1000);
        tick(3);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        e = {8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40};
`endif
        check_rx("s4_rx", e);

        // Realtime byte keeps running status; system common byte clears it.
        do_reset();
        e = {8'h90, 8'h3C, 8'hF8, 8'h90};
        foreach (e[i]) write_paced(e[i]);
        wait_idle(1000);
        tick(3);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        e = {8'h90, 8'h3C, 8'hF8};
`endif
        check_rx("s5a_rx", e);
        do_reset();
        e = {8'h90, 8'h3C, 8'hF0, 8'h90};
        foreach (e[i]) write_paced(e[i]);
        wait_idle(1000);
        tick(3);
        check_rx("s5b_rx", e);

        // Reset during data bit 3 aborts the frame and flushes the queue.
        do_reset();
        write_byte(8'h55);
        w = cyc;
        write_byte(8'h66);
        write_byte(8'h77);
        tick(w + 2 + 4 * N + 3 - cyc);
        check("s6_bit3_level", midi_out, 0);
        #100 rst = 1'b1;
        #10;
        check("s6_rst_out", midi_out, 1);
        check("s6_rst_busy", midi_busy, 0);
        check("s6_rst_full", midi_data_full, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        write_byte(8'h01);
        w = cyc;
        wait_idle(200);
        check("s6_busy_len", cyc - w, 81);
        tick(3);
        check("s6_fall_latency", (fall_q.size() > 0) ? fall_q[0] - w : -1, 2);
        e = {8'h01};
        check_rx("s6_rx", e);

        // Randomized traffic: alternating dense bursts and sparse writes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            prob = ((i / 500) % 2 == 1) ? 70 : 4;
            case ($urandom_range(0, 3))
                0:       d = ($urandom_range(0, 1) == 1) ? 8'h90 : 8'h80;
                1:       d = 8'($urandom_range(0, 127));
                2:       d = 8'($urandom_range(240, 255));
                default: d = 8'($urandom_range(0, 255));
            endcase
            midi_data = d;
            midi_data_wr = ($urandom_range(0, 99) < prob);
            tick(1);
        end
        midi_data_wr = 1'b0;
        wait_idle(2000);
        tick(3);
        check("rand_rx_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size(); i++) begin
            check($sformatf("rand_rx_byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, sent_q[i]);
        end
        check("rand_saw_overflow", (ovf_cnt > 0) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
